// File: rtl/branch_seq_ctrl_if.sv
// Branch sequencing bus between decode/ALU/fetch and branch_seq_ctrl.
// Carries the flag update path, the branch request handshake, the
// redirect/flush path towards fetch, and the resolution report.
interface branch_seq_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic              flag_we;
   logic [3:0]        flag_in;
   logic              flag_pend;
   logic              br_valid;
   logic [2:0]        br_cond;
   logic [ADDR_W-1:0] br_target;
   logic              br_ready;
   logic              stall_in;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;
   logic              br_done;
   logic              br_taken;
   logic [3:0]        flags_out;

   // Pipeline side: presents flags/branches, consumes redirect and results
   modport master (
      output flag_we, flag_in, flag_pend, br_valid, br_cond, br_target, stall_in,
      input  br_ready, redirect_valid, redirect_pc, flush, br_done, br_taken, flags_out
   );

   // Controller side
   modport slave (
      input  flag_we, flag_in, flag_pend, br_valid, br_cond, br_target, stall_in,
      output br_ready, redirect_valid, redirect_pc, flush, br_done, br_taken, flags_out
   );
endinterface

// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller for the SIMPLE core.
// Owns the {S,Z,C,V} flag register, accepts one branch at a time, waits
// for in-flight flag writers, resolves the condition, then issues the PC
// redirect and holds flush for FLUSH_CYC cycles.
// Optional macro BR_STATS_EN adds saturating taken/not-taken/stall counters.
module branch_seq_ctrl #(
   parameter int ADDR_W    = 16,
   parameter int FLUSH_CYC = 2
) (
   input  logic clk,
   input  logic rst,
`ifdef BR_STATS_EN
   output logic [15:0] stat_taken,
   output logic [15:0] stat_nottaken,
   output logic [15:0] stat_stall,
`endif
   branch_seq_ctrl_if.slave bus
);

   localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_EVAL,
      S_REDIRECT,
      S_FLUSH
   } state_t;

   state_t            state_q, state_n;
   logic [3:0]        flags_q;
   logic [2:0]        cond_q;
   logic [ADDR_W-1:0] target_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              redirect_valid_q;
   logic [ADDR_W-1:0] redirect_pc_q;
   logic              flush_q;
   logic              done_q;
   logic              taken_q;
   logic              accept;
   logic              eval_taken;

   function automatic logic cond_true(input logic [2:0] c, input logic s,
                                      input logic z, input logic v);
      logic r;
      case (c)
         3'b000:  r = z;
         3'b001:  r = s ^ v;
         3'b010:  r = z | (s ^ v);
         3'b011:  r = ~z;
         3'b100:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign bus.br_ready       = (state_q == S_IDLE) && !rst;
   assign accept             = bus.br_valid && bus.br_ready;
   assign eval_taken         = cond_true(cond_q, flags_q[3], flags_q[2], flags_q[0]);
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flush          = flush_q;
   assign bus.br_done        = done_q;
   assign bus.br_taken       = taken_q;
   assign bus.flags_out      = flags_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:     if (accept) state_n = bus.flag_pend ? S_WAIT : S_EVAL;
         S_WAIT:     if (!bus.flag_pend) state_n = S_EVAL;
         S_EVAL:     state_n = eval_taken ? S_REDIRECT : S_IDLE;
         S_REDIRECT: if (!bus.stall_in) state_n = S_FLUSH;
         S_FLUSH:    if (cnt_q == '0) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Architectural flags load on any ALU write, whatever the branch is doing
   always_ff @(posedge clk) begin
      if (rst)              flags_q <= 4'b0000;
      else if (bus.flag_we) flags_q <= bus.flag_in;
   end

   // Latch the accepted branch's condition and target
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_q   <= 3'b000;
         target_q <= '0;
      end else if (accept) begin
         cond_q   <= bus.br_cond;
         target_q <= bus.br_target;
      end
   end

   // Registered outputs and the flush down-counter
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         done_q           <= 1'b0;
         taken_q          <= 1'b0;
         cnt_q            <= '0;
      end else begin
         redirect_valid_q <= (state_n == S_REDIRECT);
         flush_q          <= (state_n == S_FLUSH);
         done_q           <= (state_q == S_EVAL);
         taken_q          <= (state_q == S_EVAL) && eval_taken;
         if (state_q == S_EVAL && eval_taken)
            redirect_pc_q <= target_q;
         if (state_q == S_REDIRECT && state_n == S_FLUSH)
            cnt_q <= CNT_W'(FLUSH_CYC - 1);
         else if (state_q == S_FLUSH && cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

`ifdef BR_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating branch statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_taken    <= 16'd0;
         stat_nottaken <= 16'd0;
         stat_stall    <= 16'd0;
      end else begin
         if (done_q && taken_q)  stat_taken    <= sat_inc(stat_taken);
         if (done_q && !taken_q) stat_nottaken <= sat_inc(stat_nottaken);
         if (state_q == S_WAIT || (state_q == S_REDIRECT && bus.stall_in))
            stat_stall <= sat_inc(stat_stall);
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Sequencing controller for the branch-condition evaluator of the SIMPLE core. It owns the architectural flag register {S,Z,C,V} and accepts one branch request at a time from decode. It stalls the request while a flag-writing instruction is in flight, resolves taken/not-taken, and drives the PC redirect and the pipeline flush window.

Parameters:
ADDR_W, 16, width of PC and branch target
FLUSH_CYC, 2, cycles flush is held after a redirect is consumed (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flag_we  in  1  ALU writes flags this cycle
flag_in  in  4  new flags {S,Z,C,V}
flag_pend  in  1  a flag-writing instruction is still in the pipe ahead of the branch
br_valid  in  1  decode presents a branch
br_cond  in  3  condition code
br_target  in  ADDR_W  branch target address
br_ready  out  1  controller can accept a branch
stall_in  in  1  fetch cannot take a redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  ADDR_W  redirect address
flush  out  1  kill younger instructions in IF/ID
br_done  out  1  one-cycle pulse when a branch resolves
br_taken  out  1  resolution result, qualified by br_done
flags_out  out  4  current flag register

Behaviour:
- Reset: state IDLE; flags, redirect_valid, redirect_pc, flush, br_done, br_taken and the latched cond/target all clear to 0; br_ready=1 out of reset.
- Flag register: loads flag_in on any edge with flag_we=1, in every state. flags_out reflects the register.
- br_ready = (state==IDLE) and rst==0. Acceptance occurs when br_valid && br_ready. On acceptance, cond and target are latched.
- Condition truth:
  - 000 BE: Z
  - 001 BLT: S^V
  - 010 BLE: Z | (S^V)
  - 011 BNE: !Z
  - 100 B: always taken
  - 101–111: never taken
- States:
  - IDLE: on acceptance, go to WAIT if flag_pend=1, else EVAL.
  - WAIT: stay while flag_pend=1; go to EVAL on the first cycle with flag_pend=0.
  - EVAL: evaluate against the flag register, which already includes any flag_we from the previous edge. Next state is REDIRECT if taken, else IDLE. br_done=1 and br_taken are registered into the next cycle.
  - REDIRECT: redirect_valid=1 and redirect_pc=target, held stable while stall_in=1. Consumed on a cycle with stall_in=0, then go to FLUSH.
  - FLUSH: flush=1 for exactly FLUSH_CYC cycles via a down-counter, then go to IDLE.
- Latency, no pending flags, stall_in=0, acceptance at cycle T:
  - EVAL at T+1.
  - br_done at T+2.
  - Taken: redirect_valid at T+2, flush during T+3..T+2+FLUSH_CYC, br_ready again at T+3+FLUSH_CYC.
  - Not-taken: br_ready again at T+2.
- Simultaneous events:
  - flag_we in the acceptance cycle or the last WAIT cycle is visible in EVAL.
  - flag_we during REDIRECT/FLUSH updates flags only.
  - br_valid outside IDLE is ignored, because br_ready=0.
- rst mid-operation, in any state: next cycle is IDLE with all outputs at reset values. A pending redirect is dropped and flush is deasserted immediately.

Optional Feature:
BR_STATS_EN
- Defined: adds outputs stat_taken[15:0], stat_nottaken[15:0] and stat_stall[15:0].
  - stat_taken / stat_nottaken increment on each br_done with br_taken=1 / 0.
  - stat_stall increments on each cycle spent in WAIT or in REDIRECT with stall_in=1.
  - All three saturate at 16'hFFFF and clear on rst.
- Undefined: none of these ports or counters exist, and the core behaviour is identical.

Test Plan:
- Reset flags via flag_we {0,1,0,0}, then BE, target 16'h0040, flag_pend=0 -> redirect_valid at T+2 with redirect_pc=16'h0040; flush high 2 cycles; br_ready back at T+5.
- flags {1,0,0,0}, BLT, then flags {1,0,0,1}, BLT -> first taken (br_taken=1), second not taken (br_done, br_taken=0, no flush, br_ready at T+2).
- BNE accepted with flag_pend=1 for 3 cycles; flag_we={0,1,0,0} coincides with flag_pend falling -> controller waits in WAIT, EVAL sees Z=1, result is not taken.
- Unconditional B, target 16'h1234, stall_in=1 for 4 cycles -> redirect_valid and redirect_pc=16'h1234 held stable 5 cycles; flush starts the cycle after stall_in drops.
- br_cond=3'b110 with all flags set -> never taken. Separately, assert rst during FLUSH -> next cycle flush=0, flags_out=0, br_ready=1.
- With BR_STATS_EN: 3 taken and 2 not-taken branches plus 4 stall cycles -> stat_taken=3, stat_nottaken=2, stat_stall=4.
